// File: rtl/sar_controller.sv
`default_nettype none
// ============================================================================
//  Module      : sar_controller
//  Description : Successive-approximation control FSM. Holds the pixel-column
//                sample/hold, walks dac_code (reference MUX select) from MSB
//                to LSB using the comparator decision for each bit, and
//                publishes the final code with a one-cycle valid strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module sar_controller #(
    parameter int width         = 2,
    parameter int sample_cycles = 2,
    parameter int settle_cycles = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             cmp,
    output logic             sample,
    output logic             busy,
    output logic [width-1:0] dac_code,
    output logic [width-1:0] result,
    output logic             valid
);

    // Counter and bit-index widths, never narrower than one bit
    localparam int SCW = (sample_cycles > 1) ? $clog2(sample_cycles) : 1;
    localparam int TCW = (settle_cycles > 1) ? $clog2(settle_cycles) : 1;
    localparam int IW  = (width > 1) ? $clog2(width) : 1;

    localparam logic [SCW-1:0]   S_LOAD = SCW'(sample_cycles - 1);
    localparam logic [TCW-1:0]   T_LOAD = TCW'(settle_cycles - 1);
    localparam logic [IW-1:0]    I_TOP  = IW'(width - 1);
    localparam logic [width-1:0] ONE    = width'(1);
    localparam logic [width-1:0] MSB    = ONE << (width - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        CONVERT = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic             sample_nxt, busy_nxt, valid_nxt;
    logic [width-1:0] dac_nxt, result_nxt;
    logic [SCW-1:0]   scnt, scnt_nxt;
    logic [TCW-1:0]   tcnt, tcnt_nxt;
    logic [IW-1:0]    idx, idx_nxt;
    logic [width-1:0] bit_mask;
    logic [width-1:0] code;

    // State and output registers; every output comes straight from a flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sample   <= 1'b0;
            busy     <= 1'b0;
            dac_code <= '0;
            result   <= '0;
            valid    <= 1'b0;
            scnt     <= '0;
            tcnt     <= '0;
            idx      <= '0;
        end else begin
            state    <= state_nxt;
            sample   <= sample_nxt;
            busy     <= busy_nxt;
            dac_code <= dac_nxt;
            result   <= result_nxt;
            valid    <= valid_nxt;
            scnt     <= scnt_nxt;
            tcnt     <= tcnt_nxt;
            idx      <= idx_nxt;
        end
    end

    // Next-state and next-output logic; abort has priority whenever busy
    always_comb begin
        state_nxt  = state;
        sample_nxt = sample;
        busy_nxt   = busy;
        dac_nxt    = dac_code;
        result_nxt = result;
        valid_nxt  = 1'b0;
        scnt_nxt   = scnt;
        tcnt_nxt   = tcnt;
        idx_nxt    = idx;
        bit_mask   = ONE << idx;
        code       = dac_code;

        if (abort && state != IDLE) begin
            state_nxt  = IDLE;
            sample_nxt = 1'b0;
            busy_nxt   = 1'b0;
            dac_nxt    = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt  = SAMPLE;
                        sample_nxt = 1'b1;
                        busy_nxt   = 1'b1;
                        dac_nxt    = '0;
                        scnt_nxt   = S_LOAD;
                    end
                end
                SAMPLE: begin
                    if (scnt != '0) begin
                        scnt_nxt = scnt - SCW'(1);
                    end else begin
                        state_nxt  = CONVERT;
                        sample_nxt = 1'b0;
                        idx_nxt    = I_TOP;
                        dac_nxt    = MSB;
                        tcnt_nxt   = T_LOAD;
                    end
                end
                CONVERT: begin
                    if (tcnt != '0) begin
                        tcnt_nxt = tcnt - TCW'(1);
                    end else begin
                        // Keep the trial bit only if vin >= reference
                        code = cmp ? dac_code : (dac_code & ~bit_mask);
                        if (idx != '0) begin
                            code     = code | (bit_mask >> 1);
                            idx_nxt  = idx - IW'(1);
                            tcnt_nxt = T_LOAD;
                            dac_nxt  = code;
                        end else begin
                            dac_nxt    = code;
                            result_nxt = code;
                            valid_nxt  = 1'b1;
                            busy_nxt   = 1'b0;
                            state_nxt  = IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sar_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sar_controller
//  Description : Self-checking bench for sar_controller (width=4,
//                sample_cycles=2, settle_cycles=2). The comparator is an
//                ideal model of a fixed input level, so a correct conversion
//                returns that level; a queue of expected completions is
//                consumed whenever valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sar_controller;

    localparam int W   = 4;
    localparam int SC  = 2;
    localparam int ST  = 2;
    localparam int LAT = SC + W * ST;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         cmp;
    logic         sample, busy, valid;
    logic [W-1:0] dac_code, result;

    int target = 0;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit prev_valid = 1'b0;

    typedef struct {
        int res;
        int cyc;
    } exp_t;
    exp_t q[$];

    sar_controller #(
        .width        (W),
        .sample_cycles(SC),
        .settle_cycles(ST)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .abort   (abort),
        .cmp     (cmp),
        .sample  (sample),
        .busy    (busy),
        .dac_code(dac_code),
        .result  (result),
        .valid   (valid)
    );

    // Ideal comparator: input level equals target
    assign cmp = (int'(dac_code) <= target);

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every valid must match the oldest outstanding conversion
    always @(negedge clk) begin
        if (valid) begin
            if (q.size() == 0) begin
                chk("unexpected_valid", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("result", int'(result), e.res);
                chk("latency_cycle", cyc, e.cyc);
                chk("busy_low_on_valid", int'(busy), 0);
            end
            if (prev_valid) chk("valid_width", 2, 1);
        end
        prev_valid = valid;
    end

    // Call just after a negedge; returns at the negedge after acceptance
    task automatic launch(input int t, input bit push);
        exp_t e;
        target = t;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (push) begin
            e.res = t;
            e.cyc = cyc + LAT;
            q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 4 * LAT; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", 1, 0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int seq [9] = '{0, 8, 8, 12, 12, 10, 10, 11, 11};

        // Reset, then idle with start low
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            chk("reset_idle_outputs", int'({sample, busy, dac_code, result, valid}), 0);
        end

        // Directed conversion of 11 with full dac_code trace
        launch(11, 1);
        chk("sample_after_accept", int'(sample), 1);
        chk("busy_after_accept", int'(busy), 1);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            chk($sformatf("dac_step%0d", k), int'(dac_code), seq[k]);
        end
        wait_idle();
        @(negedge clk);
        chk("dac_holds_final", int'(dac_code), 11);
        chk("result_holds", int'(result), 11);

        // Sweep every input level
        for (int t = 0; t < (1 << W); t++) begin
            launch(t, 1);
            wait_idle();
        end

        // Start pulse mid-conversion is ignored
        @(negedge clk);
        launch(6, 1);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Start in the valid cycle: back-to-back conversion
        @(negedge clk);
        launch(5, 1);
        wait_idle();
        chk("valid_seen_for_b2b", int'(valid), 1);
        launch(9, 1);
        chk("sample_after_b2b", int'(sample), 1);
        wait_idle();

        // Establish result=11, then abort during bit 2 of the next conversion
        @(negedge clk);
        launch(11, 1);
        wait_idle();
        @(negedge clk);
        launch(6, 0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_dac", int'(dac_code), 0);
        chk("abort_sample", int'(sample), 0);
        chk("abort_result_kept", int'(result), 11);
        repeat (LAT + 2) @(negedge clk);

        // Abort in idle does nothing; abort with start in idle still starts
        abort = 1'b1;
        @(negedge clk);
        chk("idle_abort_result", int'(result), 11);
        launch(3, 1);
        abort = 1'b0;
        wait_idle();

        // Asynchronous reset in the middle of CONVERT
        @(negedge clk);
        launch(7, 0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({sample, busy, dac_code, result, valid}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        launch(13, 1);
        wait_idle();

        // Randomised conversions, with random gaps and stray start pulses
        for (int n = 0; n < 30; n++) begin
            int t;
            t = int'($urandom_range(0, (1 << W) - 1));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            launch(t, 1);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, LAT - 4)) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            wait_idle();
        end

        repeat (4) @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
